vram_arbiter: RTL

Two-requester arbiter and access sequencer for the CPU-side ports of the three VRAM banks: vram32, vram322 and vram8. It sits between the memory unit (requester 0) and a future DMA/blitter (requester 1). It decodes a flat VRAM address into a bank and word, serialises the accesses, and returns read data through a start/busy/done handshake. The GPU-side VRAM ports are untouched.

---
 rtl/vram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: two-requester arbiter and access sequencer for the CPU-side
// ports of the vram32, vram322 and vram8 banks.
// A flat word address is decoded into a bank and a word. Accesses are
// serialised through IDLE -> ISSUE -> CAPTURE -> DONE, one access every four
// cycles. Out-of-map accesses complete normally, write nothing and read 0.
// Optional feature macro: VRAM_ARB_ROUND_ROBIN_EN. When it is defined, a
// contended grant goes to the requester that was not granted last. When it
// is not defined, requester 0 has fixed priority.
module vram_arbiter #(
   parameter int W32_WORDS = 1056,
   parameter int W8_WORDS  = 8194
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic [15:0] r0_addr,
   input  logic [31:0] r0_data,
   input  logic        r0_we,
   input  logic        r0_start,
   output logic        r0_busy,
   output logic        r0_done,
   output logic [31:0] r0_q,
   input  logic [15:0] r1_addr,
   input  logic [31:0] r1_data,
   input  logic        r1_we,
   input  logic        r1_start,
   output logic        r1_busy,
   output logic        r1_done,
   output logic [31:0] r1_q,
   output logic [13:0] vram32_addr,
   output logic [31:0] vram32_d,
   output logic        vram32_we,
   input  logic [31:0] vram32_q,
   output logic [13:0] vram322_addr,
   output logic [31:0] vram322_d,
   output logic        vram322_we,
   input  logic [31:0] vram322_q,
   output logic [13:0] vram8_addr,
   output logic [7:0]  vram8_d,
   output logic        vram8_we,
   input  logic [7:0]  vram8_q
);

   localparam logic [15:0] LIM_32    = 16'(W32_WORDS);
   localparam logic [15:0] LIM_322   = 16'(2 * W32_WORDS);
   localparam logic [15:0] LIM_8     = 16'(2 * W32_WORDS + W8_WORDS);
   localparam logic [1:0]  BANK_32   = 2'd0;
   localparam logic [1:0]  BANK_322  = 2'd1;
   localparam logic [1:0]  BANK_8    = 2'd2;
   localparam logic [1:0]  BANK_NONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Bank selected by a flat address; anything past vram8 is unmapped.
   function automatic logic [1:0] bank_of(input logic [15:0] a);
      logic [1:0] b;
      if (a < LIM_32) begin
         b = BANK_32;
      end else if (a < LIM_322) begin
         b = BANK_322;
      end else if (a < LIM_8) begin
         b = BANK_8;
      end else begin
         b = BANK_NONE;
      end
      return b;
   endfunction

   // Word offset inside the selected bank.
   function automatic logic [13:0] word_of(input logic [15:0] a);
      logic [15:0] w;
      if (a < LIM_32) begin
         w = a;
      end else if (a < LIM_322) begin
         w = a - LIM_32;
      end else begin
         w = a - LIM_322;
      end
      return 14'(w);
   endfunction

   state_t      state_r, next_s;
   logic [1:0]  start_s;
   logic [15:0] in_addr_s [2];
   logic [31:0] in_data_s [2];
   logic [1:0]  in_we_s;
   logic [1:0]  pend_r;
   logic [15:0] addr_r [2];
   logic [31:0] data_r [2];
   logic [1:0]  we_r;
   logic        gnt_s, gnt_r;
   logic        grant_s;
   logic [1:0]  bank_r;
   logic [15:0] sel_addr_s;
   logic [31:0] sel_data_s;
   logic        sel_we_s;
   logic [1:0]  sel_bank_s;
   logic [13:0] sel_word_s;
   logic [31:0] cap_s;
   logic [1:0]  done_r;
   logic [31:0] q_r [2];
   logic [13:0] vram32_addr_r, vram322_addr_r, vram8_addr_r;
   logic [31:0] vram32_d_r, vram322_d_r;
   logic [7:0]  vram8_d_r;
   logic        vram32_we_r, vram322_we_r, vram8_we_r;

   assign start_s      = {r1_start, r0_start};
   assign in_addr_s[0] = r0_addr;
   assign in_addr_s[1] = r1_addr;
   assign in_data_s[0] = r0_data;
   assign in_data_s[1] = r1_data;
   assign in_we_s      = {r1_we, r0_we};

   // Pending flags and request fields: set by an accepted start, cleared on completion.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pend_r <= 2'b00;
         we_r   <= 2'b00;
         for (int n = 0; n < 2; n++) begin
            addr_r[n] <= 16'd0;
            data_r[n] <= 32'd0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if ((state_r == CAPTURE) && (gnt_r == 1'(n))) begin
               pend_r[n] <= 1'b0;
            end else if (start_s[n] && !pend_r[n]) begin
               pend_r[n] <= 1'b1;
               addr_r[n] <= in_addr_s[n];
               data_r[n] <= in_data_s[n];
               we_r[n]   <= in_we_s[n];
            end else begin
               pend_r[n] <= pend_r[n];
            end
         end
      end
   end

`ifdef VRAM_ARB_ROUND_ROBIN_EN
   logic last_r;

   // Round-robin pointer: remembers the requester granted most recently.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         last_r <= 1'b1;
      end else if (grant_s) begin
         last_r <= gnt_s;
      end else begin
         last_r <= last_r;
      end
   end
`endif

   // Grant choice among the pending requesters.
   always_comb begin
      gnt_s = 1'b0;
      if (pend_r == 2'b11) begin
`ifdef VRAM_ARB_ROUND_ROBIN_EN
         gnt_s = ~last_r;
`else
         gnt_s = 1'b0;
`endif
      end else if (pend_r[1]) begin
         gnt_s = 1'b1;
      end else begin
         gnt_s = 1'b0;
      end
   end

   assign grant_s    = (state_r == IDLE) && (pend_r != 2'b00);
   assign sel_addr_s = gnt_s ? addr_r[1] : addr_r[0];
   assign sel_data_s = gnt_s ? data_r[1] : data_r[0];
   assign sel_we_s   = gnt_s ? we_r[1] : we_r[0];
   assign sel_bank_s = bank_of(sel_addr_s);
   assign sel_word_s = word_of(sel_addr_s);

   // Sequencer state register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Sequencer next state: each access walks through four fixed cycles.
   always_comb begin
      next_s = IDLE;
      case (state_r)
         IDLE: begin
            if (pend_r != 2'b00) begin
               next_s = ISSUE;
            end else begin
               next_s = IDLE;
            end
         end
         ISSUE:   next_s = CAPTURE;
         CAPTURE: next_s = DONE;
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Bank port drive: address and data are loaded at grant and held; write enable lasts only for ISSUE.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         gnt_r          <= 1'b0;
         bank_r         <= BANK_32;
         vram32_addr_r  <= 14'd0;
         vram322_addr_r <= 14'd0;
         vram8_addr_r   <= 14'd0;
         vram32_d_r     <= 32'd0;
         vram322_d_r    <= 32'd0;
         vram8_d_r      <= 8'd0;
         vram32_we_r    <= 1'b0;
         vram322_we_r   <= 1'b0;
         vram8_we_r     <= 1'b0;
      end else begin
         vram32_we_r  <= 1'b0;
         vram322_we_r <= 1'b0;
         vram8_we_r   <= 1'b0;
         if (grant_s) begin
            gnt_r  <= gnt_s;
            bank_r <= sel_bank_s;
            case (sel_bank_s)
               BANK_32: begin
                  vram32_addr_r <= sel_word_s;
                  vram32_d_r    <= sel_data_s;
                  vram32_we_r   <= sel_we_s;
               end
               BANK_322: begin
                  vram322_addr_r <= sel_word_s;
                  vram322_d_r    <= sel_data_s;
                  vram322_we_r   <= sel_we_s;
               end
               BANK_8: begin
                  vram8_addr_r <= sel_word_s;
                  vram8_d_r    <= sel_data_s[7:0];
                  vram8_we_r   <= sel_we_s;
               end
               default: begin
                  vram32_we_r <= 1'b0;
               end
            endcase
         end else begin
            gnt_r <= gnt_r;
         end
      end
   end

   // Read data returned by the bank that was accessed; unmapped reads as 0.
   always_comb begin
      cap_s = 32'd0;
      case (bank_r)
         BANK_32:  cap_s = vram32_q;
         BANK_322: cap_s = vram322_q;
         BANK_8:   cap_s = {24'd0, vram8_q};
         default:  cap_s = 32'd0;
      endcase
   end

   // Completion: capture read data and raise a one-cycle done for the granted requester.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         done_r <= 2'b00;
         q_r[0] <= 32'd0;
         q_r[1] <= 32'd0;
      end else begin
         done_r <= 2'b00;
         if (state_r == CAPTURE) begin
            done_r[gnt_r] <= 1'b1;
            q_r[gnt_r]    <= cap_s;
         end else begin
            done_r <= 2'b00;
         end
      end
   end

   assign r0_busy      = pend_r[0];
   assign r1_busy      = pend_r[1];
   assign r0_done      = done_r[0];
   assign r1_done      = done_r[1];
   assign r0_q         = q_r[0];
   assign r1_q         = q_r[1];
   assign vram32_addr  = vram32_addr_r;
   assign vram32_d     = vram32_d_r;
   assign vram32_we    = vram32_we_r;
   assign vram322_addr = vram322_addr_r;
   assign vram322_d    = vram322_d_r;
   assign vram322_we   = vram322_we_r;
   assign vram8_addr   = vram8_addr_r;
   assign vram8_d      = vram8_d_r;
   assign vram8_we     = vram8_we_r;

endmodule
